// File: rtl/bscan_channel_arb_if.sv
// Handshake bundle between the BSCAN channel arbiter, its on-chip requesters and the Bscan mailbox.
// slave is the arbiter's view; master is the environment driving requests, Bscan readiness and responses.
interface bscan_channel_arb_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]    req__ENA;
  logic [NUM_CH*28-1:0] req__v;
  logic [NUM_CH-1:0]    req__RDY;
  logic                 to_bscan__ENA;
  logic [31:0]          to_bscan__v;
  logic                 to_bscan__RDY;
  logic                 from_bscan__ENA;
  logic [31:0]          from_bscan__v;
  logic                 from_bscan__RDY;
  logic [NUM_CH-1:0]    rsp__ENA;
  logic [27:0]          rsp__v;
  logic [NUM_CH-1:0]    rsp__RDY;

  modport slave (
    input  req__ENA, req__v, to_bscan__RDY, from_bscan__ENA, from_bscan__v, rsp__RDY,
    output req__RDY, to_bscan__ENA, to_bscan__v, from_bscan__RDY, rsp__ENA, rsp__v
  );

  modport master (
    output req__ENA, req__v, to_bscan__RDY, from_bscan__ENA, from_bscan__v, rsp__RDY,
    input  req__RDY, to_bscan__ENA, to_bscan__v, from_bscan__RDY, rsp__ENA, rsp__v
  );
endinterface

// File: rtl/bscan_channel_arb.sv
// Round-robin arbiter sharing one 32-bit JTAG BSCAN mailbox among NUM_CH requesters,
// with one request outstanding at a time and id-tagged response routing.
module bscan_channel_arb #(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  bscan_channel_arb_if.slave   bus,
  output logic                 busy,
  output logic [3:0]           grant,
  output logic [CNT_W-1:0]     timeout_cnt,
  output logic [CNT_W-1:0]     stray_cnt
);
  localparam int DATA_W = 28;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DELIVER} state_t;

  state_t              state, state_nxt;
  logic [NUM_CH-1:0]   pend_v;
  logic [DATA_W-1:0]   pend_d [NUM_CH];
  logic [31:0]         out_word;
  logic [DATA_W-1:0]   rsp_data;
  logic [15:0]         timer;
  logic [NUM_CH-1:0]   grant_oh;
  logic                pick_vld;
  logic [3:0]          pick_id;
  logic [DATA_W-1:0]   pick_data;
  logic                rsp_match, timed_out, send_fire, dlv_fire, stray;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) grant_oh[i] = (grant == 4'(i));
  end

  // Round-robin search: the first pending slot at or after grant+1 wins.
  always_comb begin
    pick_vld  = 1'b0;
    pick_id   = '0;
    pick_data = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!pick_vld && pend_v[i] && (((int'(grant) + k) % NUM_CH) == i)) begin
          pick_vld  = 1'b1;
          pick_id   = 4'(i);
          pick_data = pend_d[i];
        end
      end
    end
  end

  assign rsp_match = (state == WAIT) && bus.from_bscan__ENA && (bus.from_bscan__v[31:28] == grant);
  assign timed_out = (state == WAIT) && !rsp_match && (timer == TMO_LAST);
  assign send_fire = (state == SEND) && bus.to_bscan__RDY;
  assign dlv_fire  = (state == DELIVER) && |(bus.rsp__RDY & grant_oh);
  // Anything not matching the outstanding request is discarded, including ids >= NUM_CH.
  assign stray     = bus.from_bscan__ENA && !rsp_match;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = SEND;
      SEND:    if (send_fire) state_nxt = WAIT;
      WAIT:    if (rsp_match) state_nxt = DELIVER;
               else if (timed_out) state_nxt = IDLE;
      DELIVER: if (dlv_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.to_bscan__ENA   = 1'b0;
    bus.rsp__ENA        = '0;
    bus.from_bscan__RDY = 1'b1;
    busy                = 1'b1;
    case (state)
      IDLE:    busy = 1'b0;
      SEND:    bus.to_bscan__ENA = bus.to_bscan__RDY;
      DELIVER: begin
        bus.rsp__ENA        = bus.rsp__RDY & grant_oh;
        bus.from_bscan__RDY = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.req__RDY    = ~pend_v;
  assign bus.to_bscan__v = out_word;
  assign bus.rsp__v      = rsp_data;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pend_v      <= '0;
      grant       <= 4'(NUM_CH - 1);
      timer       <= '0;
      timeout_cnt <= '0;
      stray_cnt   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.req__ENA[i])             pend_v[i] <= 1'b1;
        else if (send_fire && grant_oh[i]) pend_v[i] <= 1'b0;
      end
      if (state == IDLE && pick_vld) grant <= pick_id;
      if (send_fire)              timer <= '0;
      else if (state == WAIT)     timer <= timer + 16'd1;
      if (timed_out) timeout_cnt <= sat_inc(timeout_cnt);
      if (stray)     stray_cnt   <= sat_inc(stray_cnt);
    end
  end

  // Payload registers carry no reset; their contents are qualified by pend_v and the FSM state.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.req__ENA[i]) pend_d[i] <= bus.req__v[DATA_W*i +: DATA_W];
    end
    if (state == IDLE && pick_vld) out_word <= {pick_id, pick_data};
    if (rsp_match)                 rsp_data <= bus.from_bscan__v[DATA_W-1:0];
  end
endmodule

// File: tb/tb_bscan_channel_arb.sv
// Directed bench for bscan_channel_arb: NUM_CH=4, TIMEOUT=8, one task per scenario.
module tb_bscan_channel_arb;
  logic       CLK = 1'b0;
  logic       nRST;
  logic       busy;
  logic [3:0] grant;
  logic [15:0] timeout_cnt, stray_cnt;
  int checks = 0;
  int errors = 0;

  bscan_channel_arb_if #(.NUM_CH(4)) bus ();

  bscan_channel_arb #(.NUM_CH(4), .TIMEOUT(8), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus), .busy(busy), .grant(grant),
    .timeout_cnt(timeout_cnt), .stray_cnt(stray_cnt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    nRST = 1'b0;
    bus.req__ENA = '0;
    bus.from_bscan__ENA = 1'b0;
    bus.to_bscan__RDY = 1'b1;
    bus.rsp__RDY = 4'hF;
    tick;
    tick;
    nRST = 1'b1;
    #1;
  endtask

  task automatic wait_send(output logic ok, output logic [31:0] w);
    ok = 1'b0;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      if (bus.to_bscan__ENA === 1'b1) begin
        ok = 1'b1;
        w = bus.to_bscan__v;
        break;
      end
      tick;
      #1;
    end
  endtask

  // Carry one grant through send, immediate response (payload ^ 5A5A5A5) and delivery.
  task automatic do_txn(output logic ok, output logic [31:0] w,
                        output logic [3:0] ren, output logic [27:0] rpl);
    ren = '0;
    rpl = '0;
    wait_send(ok, w);
    if (!ok) return;
    tick;
    bus.from_bscan__ENA = 1'b1;
    bus.from_bscan__v = {w[31:28], w[27:0] ^ 28'h5A5A5A5};
    #1;
    tick;
    bus.from_bscan__ENA = 1'b0;
    #1;
    ren = bus.rsp__ENA;
    rpl = bus.rsp__v;
    tick;
    #1;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    bus.req__ENA = '0;
    bus.req__v = '0;
    bus.to_bscan__RDY = 1'b1;
    bus.from_bscan__ENA = 1'b0;
    bus.from_bscan__v = '0;
    bus.rsp__RDY = 4'hF;
    tick;
    tick;
    #1;
    checks++;
    if ({bus.to_bscan__ENA, bus.rsp__ENA, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ena got to=%b rsp=%b busy=%b want 0", bus.to_bscan__ENA, bus.rsp__ENA, busy);
    end
    checks++;
    if (grant !== 4'd3) begin errors++; $display("FAIL reset_grant got %0d want 3", grant); end
    checks++;
    if ({timeout_cnt, stray_cnt} !== 32'h0) begin
      errors++; $display("FAIL reset_cnt got tmo=%0d stray=%0d want 0", timeout_cnt, stray_cnt);
    end
    checks++;
    if ({bus.req__RDY, bus.from_bscan__RDY} !== 5'b11111) begin
      errors++; $display("FAIL reset_rdy got req=%b from=%b want 1111/1", bus.req__RDY, bus.from_bscan__RDY);
    end
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_single;
    do_reset;
    tick;
    bus.req__ENA = 4'b0100;
    bus.req__v[56 +: 28] = 28'h0ABCDEF;
    #1;
    tick;
    bus.req__ENA = '0;
    #1;
    checks++;
    if ({bus.req__RDY, bus.to_bscan__ENA} !== 5'b1011_0) begin
      errors++; $display("FAIL single_slot got rdy=%b ena=%b want 1011/0", bus.req__RDY, bus.to_bscan__ENA);
    end
    tick;
    #1;
    checks++;
    if (bus.to_bscan__ENA !== 1'b1 || bus.to_bscan__v !== 32'h20ABCDEF) begin
      errors++; $display("FAIL single_send got ena=%b v=%h want 1/20abcdef", bus.to_bscan__ENA, bus.to_bscan__v);
    end
    tick;
    bus.from_bscan__ENA = 1'b1;
    bus.from_bscan__v = 32'h21234567;
    #1;
    checks++;
    if (bus.req__RDY !== 4'hF || busy !== 1'b1) begin
      errors++; $display("FAIL single_wait got rdy=%b busy=%b want 1111/1", bus.req__RDY, busy);
    end
    tick;
    bus.from_bscan__ENA = 1'b0;
    #1;
    checks++;
    if (bus.rsp__ENA !== 4'b0100 || bus.rsp__v !== 28'h1234567) begin
      errors++; $display("FAIL single_rsp got ena=%b v=%h want 0100/1234567", bus.rsp__ENA, bus.rsp__v);
    end
    tick;
    #1;
    checks++;
    if (busy !== 1'b0 || grant !== 4'd2) begin
      errors++; $display("FAIL single_idle got busy=%b grant=%0d want 0/2", busy, grant);
    end
  endtask

  task automatic test_round_robin;
    logic [27:0] pay [4];
    logic [3:0]  order [6];
    logic        ok;
    logic [31:0] w;
    logic [3:0]  ren;
    logic [27:0] rpl;
    pay = '{28'h0A00000, 28'h0B11111, 28'h0C22222, 28'h0D33333};
    order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd3};
    do_reset;
    for (int round = 0; round < 2; round++) begin
      tick;
      bus.req__ENA = (round == 0) ? 4'b1111 : 4'b1001;
      bus.req__v = {pay[3], pay[2], pay[1], pay[0]};
      #1;
      tick;
      bus.req__ENA = '0;
      #1;
      for (int j = 0; j < ((round == 0) ? 4 : 2); j++) begin
        int e;
        e = int'(order[round * 4 + j]);
        do_txn(ok, w, ren, rpl);
        checks++;
        if (!ok || w !== {4'(e), pay[e]}) begin
          errors++; $display("FAIL rr_send r%0d j%0d got ok=%b w=%h want %h", round, j, ok, w, {4'(e), pay[e]});
        end
        checks++;
        if (ren !== 4'(1 << e) || rpl !== (pay[e] ^ 28'h5A5A5A5)) begin
          errors++; $display("FAIL rr_rsp r%0d j%0d got ena=%b v=%h want %b/%h", round, j, ren, rpl,
                             4'(1 << e), pay[e] ^ 28'h5A5A5A5);
        end
      end
    end
  endtask

  task automatic test_timeout;
    logic        ok, saw_rsp;
    logic [31:0] w;
    logic [3:0]  ren;
    logic [27:0] rpl;
    int n;
    do_reset;
    tick;
    bus.req__ENA = 4'b0110;
    bus.req__v = {28'h0, 28'h0222222, 28'h0111111, 28'h0};
    #1;
    tick;
    bus.req__ENA = '0;
    #1;
    wait_send(ok, w);
    checks++;
    if (!ok || w !== 32'h10111111) begin
      errors++; $display("FAIL tmo_first got ok=%b w=%h want 10111111", ok, w);
    end
    tick;
    #1;
    n = 0;
    saw_rsp = 1'b0;
    while (busy === 1'b1 && n < 20) begin
      saw_rsp |= |bus.rsp__ENA;
      n++;
      tick;
      #1;
    end
    checks++;
    if (n !== 8 || saw_rsp !== 1'b0) begin
      errors++; $display("FAIL tmo_wait got cycles=%0d rsp=%b want 8/0", n, saw_rsp);
    end
    checks++;
    if (timeout_cnt !== 16'd1) begin errors++; $display("FAIL tmo_cnt got %0d want 1", timeout_cnt); end
    do_txn(ok, w, ren, rpl);
    checks++;
    if (!ok || w !== 32'h20222222 || ren !== 4'b0100) begin
      errors++; $display("FAIL tmo_next got ok=%b w=%h ena=%b want 20222222/0100", ok, w, ren);
    end
  endtask

  task automatic test_stray;
    logic        ok;
    logic [31:0] w;
    do_reset;
    tick;
    bus.req__ENA = 4'b0001;
    bus.req__v = {84'h0, 28'h0000042};
    #1;
    tick;
    bus.req__ENA = '0;
    #1;
    wait_send(ok, w);
    checks++;
    if (!ok || w !== 32'h00000042) begin errors++; $display("FAIL stray_send got ok=%b w=%h want 00000042", ok, w); end
    tick;
    bus.from_bscan__ENA = 1'b1;
    bus.from_bscan__v = 32'h15555555;
    #1;
    tick;
    bus.from_bscan__ENA = 1'b0;
    #1;
    checks++;
    if (stray_cnt !== 16'd1 || busy !== 1'b1 || bus.rsp__ENA !== 4'b0 || bus.from_bscan__RDY !== 1'b1) begin
      errors++; $display("FAIL stray_drop got cnt=%0d busy=%b ena=%b rdy=%b want 1/1/0000/1",
                         stray_cnt, busy, bus.rsp__ENA, bus.from_bscan__RDY);
    end
    bus.from_bscan__ENA = 1'b1;
    bus.from_bscan__v = 32'h07654321;
    #1;
    tick;
    bus.from_bscan__ENA = 1'b0;
    #1;
    checks++;
    if (bus.rsp__ENA !== 4'b0001 || bus.rsp__v !== 28'h7654321) begin
      errors++; $display("FAIL stray_match got ena=%b v=%h want 0001/7654321", bus.rsp__ENA, bus.rsp__v);
    end
  endtask

  task automatic test_exact_timeout;
    logic        ok;
    logic [31:0] w;
    int bad;
    do_reset;
    bus.rsp__RDY = 4'h0;
    tick;
    bus.req__ENA = 4'b1000;
    bus.req__v = {28'h0ABCDEF, 84'h0};
    #1;
    tick;
    bus.req__ENA = '0;
    #1;
    wait_send(ok, w);
    checks++;
    if (!ok || w !== 32'h30ABCDEF) begin errors++; $display("FAIL edge_send got ok=%b w=%h want 30abcdef", ok, w); end
    tick;
    repeat (7) tick;
    bus.from_bscan__ENA = 1'b1;
    bus.from_bscan__v = 32'h3ABCDEF0;
    #1;
    tick;
    bus.from_bscan__ENA = 1'b0;
    #1;
    checks++;
    if (timeout_cnt !== 16'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL edge_cnt got tmo=%0d busy=%b want 0/1", timeout_cnt, busy);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.from_bscan__RDY !== 1'b0 || bus.rsp__ENA !== 4'b0) bad++;
      tick;
      #1;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL edge_hold got bad_cycles=%0d want 0", bad); end
    bus.rsp__RDY = 4'hF;
    #1;
    checks++;
    if (bus.rsp__ENA !== 4'b1000 || bus.rsp__v !== 28'hABCDEF0) begin
      errors++; $display("FAIL edge_rsp got ena=%b v=%h want 1000/abcdef0", bus.rsp__ENA, bus.rsp__v);
    end
    tick;
    #1;
    checks++;
    if (busy !== 1'b0 || timeout_cnt !== 16'd0) begin
      errors++; $display("FAIL edge_done got busy=%b tmo=%0d want 0/0", busy, timeout_cnt);
    end
  endtask

  task automatic test_reset_mid;
    logic        ok;
    logic [31:0] w;
    do_reset;
    tick;
    bus.from_bscan__ENA = 1'b1;
    bus.from_bscan__v = 32'h0000BEEF;
    bus.req__ENA = 4'b0010;
    bus.req__v = {56'h0, 28'h0123456, 28'h0};
    #1;
    tick;
    bus.from_bscan__ENA = 1'b0;
    bus.req__ENA = '0;
    #1;
    wait_send(ok, w);
    tick;
    #1;
    checks++;
    if (!ok || stray_cnt !== 16'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre got ok=%b stray=%0d busy=%b want 1/1/1", ok, stray_cnt, busy);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || grant !== 4'd3 || {timeout_cnt, stray_cnt} !== 32'h0 ||
        bus.to_bscan__ENA !== 1'b0 || bus.rsp__ENA !== 4'b0 || bus.req__RDY !== 4'hF ||
        bus.from_bscan__RDY !== 1'b1) begin
      errors++; $display("FAIL rst_mid got busy=%b grant=%0d stray=%0d tmo=%0d rdy=%b want 0/3/0/0/1111",
                         busy, grant, stray_cnt, timeout_cnt, bus.req__RDY);
    end
    tick;
    nRST = 1'b1;
    bus.from_bscan__ENA = 1'b1;
    bus.from_bscan__v = 32'h10000042;
    #1;
    tick;
    bus.from_bscan__ENA = 1'b0;
    #1;
    checks++;
    if (stray_cnt !== 16'd1 || bus.rsp__ENA !== 4'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_late got stray=%0d ena=%b busy=%b want 1/0000/0", stray_cnt, bus.rsp__ENA, busy);
    end
    tick;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.to_bscan__ENA !== 1'b0) begin
      errors++; $display("FAIL rst_nogrant got busy=%b ena=%b want 0/0", busy, bus.to_bscan__ENA);
    end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_timeout;
    test_stray;
    test_exact_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
